fir_tap_scheduler: RTL and testbench
====================================

// Module: fir_tap_scheduler
// PURPOSE
// Sequencer for the time-multiplexed stereo FIR datapath in dsp_unit. On each
// sample tick it writes the new sample pair into the history RAMs, then steps one
// shared multiply-accumulate through FILTER_TAPS taps for left, then right,
// generating coefficient/history addresses and MAC controls. Coefficients sit in
// DSP regs: left = index 0..TAPS-1, right = TAPS..2*TAPS-1. Runs in clk domain.
// PARAMETERS
// FILTER_TAPS  53  taps per channel (2*FILTER_TAPS = DSP_REGISTERS)
// MAC_LAT      2   cycles from mac_en to accumulator update (MAC pipeline depth)
// PORTS
// clk            in   1   system clock
// rst            in   1   asynchronous reset, active-high
// tick_in        in   1   one-cycle pulse: new sample pair available
// filter_en      in   1   CFG_REG[CFG_FILTER]; sampled on accepted tick
// clr_in         in   1   synchronous clear (CMD_CLR)
// coef_addr      out  7   DSP coefficient index 0..2*TAPS-1
// hist_addr      out  6   history RAM address 0..TAPS-1 (both channels)
// hist_we        out  1   write new sample pair at hist_addr
// mac_en         out  1   MAC consumes coef/hist operands this cycle
// mac_clr        out  1   with mac_en: load product instead of accumulate
// mac_ch         out  1   0 = left accumulator, 1 = right
// bypass         out  1   output mux selects raw sample (filter off)
// out_valid      out  1   one-cycle pulse: both channel results valid
// busy           out  1   high from accepted tick until out_valid cycle inclusive
// overrun        out  1   one-cycle pulse: tick arrived while busy
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; wr_ptr = 0. Reset mid-run aborts at once.
// - States: IDLE, LOAD, LEFT, RIGHT, DRAIN, DONE. Tick accepted only in IDLE.
// - Accepted tick at cycle T: IDLE->LOAD. filter_en latched.
// - LOAD (T+1): hist_we=1, hist_addr=wr_ptr; latch base=wr_ptr; wr_ptr =
//   (wr_ptr==TAPS-1) ? 0 : wr_ptr+1. If filter off -> DONE, else -> LEFT.
// - LEFT (T+2..T+1+TAPS): tap k=0..TAPS-1: mac_en=1, mac_ch=0, coef_addr=k,
//   hist_addr=(base-k) mod TAPS, mac_clr=(k==0).
// - RIGHT (next TAPS cycles): same with mac_ch=1, coef_addr=TAPS+k.
// - DRAIN: MAC_LAT cycles, mac_en=0. Then DONE: out_valid=1, busy=0 next cycle.
// - Filter on latency: out_valid at T+2+2*TAPS+MAC_LAT (T+110 default);
//   must not exceed DSP_UNIT_MAX_LATENCY (131 cycles).
// - Filter off: bypass=1 from LOAD through DONE; out_valid at T+2; no mac_en.
// - mac_en, hist_we never both 1. coef/hist_addr hold last value when idle.
// - Tick while busy: ignored, overrun=1 same cycle; current run unaffected.
// - clr_in: next cycle state IDLE, wr_ptr=0, outputs 0, no out_valid for aborted run.
//   clr_in and tick_in together: clr wins, tick dropped, no overrun.
// - Modulo subtraction: (base-k) computed as base-k+TAPS when k>base; widths
//   $clog2(TAPS) and $clog2(2*TAPS).
// TESTING
// 1. Assert rst mid-LEFT -> all outputs 0 async; next tick restarts from wr_ptr=0.
// 2. filter_en=1, tick at T -> hist_we@T+1 addr 0; coef_addr 0..52 @T+2..T+54,
//    53..105 @T+55..T+107; mac_clr @T+2,T+55; out_valid @T+110.
// 3. Second tick (wr_ptr=1): LEFT hist_addr sequence 1,0,52,51,...,2.
// 4. 53 ticks -> wr_ptr wraps to 0; 54th tick writes hist_addr 0.
// 5. Tick at T+40 during run -> overrun pulse @T+40; out_valid still @T+110 only.
// 6. filter_en=0 tick -> bypass=1, out_valid @T+2, mac_en never high;
//    clr_in at T+30 of filter-on run -> IDLE @T+31, no out_valid.

Source files
------------

// File: rtl/fir_tap_scheduler.sv
// Tap sequencer for the shared stereo FIR MAC: writes each sample pair into the
// history RAMs, then walks left taps, right taps, drains the MAC and flags the result.
module fir_tap_scheduler #(
    parameter int FILTER_TAPS = 53,
    parameter int MAC_LAT     = 2,
    localparam int AW = $clog2(FILTER_TAPS),
    localparam int KW = $clog2(2 * FILTER_TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_in,
    input  logic          filter_en,
    input  logic          clr_in,
    output logic [KW-1:0] coef_addr,
    output logic [AW-1:0] hist_addr,
    output logic          hist_we,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          mac_ch,
    output logic          bypass,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [2:0] {IDLE, LOAD, LEFT, RIGHT, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] base_q, base_d;
    logic          byp_q, byp_d;
    logic [KW-1:0] coef_q, coef_d;
    logic [AW-1:0] hist_q, hist_d;

    // History slot of tap k relative to the newest sample, wrapping into the ring.
    function automatic logic [AW-1:0] hmod(input logic [AW-1:0] b, input logic [KW-1:0] k);
        logic [KW-1:0] bw;
        bw = KW'(b);
        if (k > bw) return AW'(bw + KW'(FILTER_TAPS) - k);
        else        return AW'(bw - k);
    endfunction

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wr_ptr_d = wr_ptr_q;
        byp_d    = byp_q;
        base_d   = (state_q == LOAD) ? wr_ptr_q : base_q;
        case (state_q)
            IDLE: if (tick_in) begin
                state_d = LOAD;
                byp_d   = ~filter_en;
                k_d     = '0;
            end
            LOAD: begin
                wr_ptr_d = (wr_ptr_q == AW'(FILTER_TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
                state_d  = byp_q ? DONE : LEFT;
                k_d      = '0;
            end
            LEFT: if (k_q == KW'(FILTER_TAPS - 1)) begin
                state_d = RIGHT;
                k_d     = '0;
            end else k_d = k_q + 1'b1;
            RIGHT: if (k_q == KW'(FILTER_TAPS - 1)) begin
                state_d = DRAIN;
                k_d     = '0;
            end else k_d = k_q + 1'b1;
            DRAIN: if (k_q == KW'(MAC_LAT - 1)) state_d = DONE;
                   else k_d = k_q + 1'b1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr_in) begin
            state_d  = IDLE;
            k_d      = '0;
            wr_ptr_d = '0;
            byp_d    = 1'b0;
        end
    end

    // Addresses are registered from the next state so they hold while idle.
    always_comb begin
        coef_d = coef_q;
        hist_d = hist_q;
        case (state_d)
            LOAD:  hist_d = wr_ptr_q;
            LEFT: begin
                coef_d = k_d;
                hist_d = hmod(base_d, k_d);
            end
            RIGHT: begin
                coef_d = k_d + KW'(FILTER_TAPS);
                hist_d = hmod(base_d, k_d);
            end
            default: ;
        endcase
        if (clr_in) begin
            coef_d = '0;
            hist_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            wr_ptr_q <= '0;
            base_q   <= '0;
            byp_q    <= 1'b0;
            coef_q   <= '0;
            hist_q   <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            wr_ptr_q <= wr_ptr_d;
            base_q   <= base_d;
            byp_q    <= byp_d;
            coef_q   <= coef_d;
            hist_q   <= hist_d;
        end
    end

    assign coef_addr = coef_q;
    assign hist_addr = hist_q;
    assign hist_we   = (state_q == LOAD);
    assign mac_en    = (state_q == LEFT) || (state_q == RIGHT);
    assign mac_clr   = mac_en && (k_q == '0);
    assign mac_ch    = (state_q == RIGHT);
    assign bypass    = byp_q && ((state_q == LOAD) || (state_q == DONE));
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign overrun   = tick_in && busy && !clr_in;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Scoreboard bench for fir_tap_scheduler: stimulus queues expected output events,
// a negedge monitor pops and compares whenever the DUT shows any activity.
module tb_fir_tap_scheduler;
    localparam int TAPS = 53;
    localparam int LAT  = 2;

    logic       clk = 1'b0, rst, tick_in, filter_en, clr_in;
    logic [6:0] coef_addr;
    logic [5:0] hist_addr;
    logic       hist_we, mac_en, mac_clr, mac_ch, bypass, out_valid, busy, overrun;

    fir_tap_scheduler #(.FILTER_TAPS(TAPS), .MAC_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .filter_en(filter_en), .clr_in(clr_in),
        .coef_addr(coef_addr), .hist_addr(hist_addr), .hist_we(hist_we), .mac_en(mac_en),
        .mac_clr(mac_clr), .mac_ch(mac_ch), .bypass(bypass), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       hwe, men, mclr, mch, byp, ov, ovr, chk_c, chk_h;
        logic [6:0] coef;
        logic [5:0] hist;
    } ev_t;

    ev_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue every expected event of a run ticked at cycle t, up to offset cut.
    task automatic exp_run(input int t, input bit f, input int base, input int ovr, input int cut);
        ev_t e;
        e = '{default: 0};
        e.cyc = t + 1; e.hwe = 1; e.byp = !f; e.chk_h = 1; e.hist = 6'(base);
        e.ovr = (ovr == 1);
        if (cut >= 1) sb.push_back(e);
        if (!f) begin
            e = '{default: 0};
            e.cyc = t + 2; e.ov = 1; e.byp = 1; e.ovr = (ovr == 2);
            if (cut >= 2) sb.push_back(e);
            return;
        end
        for (int ch = 0; ch < 2; ch++)
            for (int k = 0; k < TAPS; k++) begin
                e = '{default: 0};
                e.cyc  = t + 2 + ch * TAPS + k;
                e.men  = 1; e.mclr = (k == 0); e.mch = ch[0];
                e.chk_c = 1; e.chk_h = 1;
                e.coef = 7'(ch * TAPS + k);
                e.hist = 6'(((base - k) % TAPS + TAPS) % TAPS);
                e.ovr  = (e.cyc - t == ovr);
                if (e.cyc - t <= cut) sb.push_back(e);
            end
        e = '{default: 0};
        e.cyc = t + 2 + 2 * TAPS + LAT; e.ov = 1;
        if (e.cyc - t <= cut) sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (hist_we || mac_en || out_valid || overrun)) begin
            ev_t e;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d we=%b mac=%b ov=%b ovr=%b", cyc, hist_we, mac_en, out_valid, overrun);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || hist_we !== e.hwe || mac_en !== e.men || mac_clr !== e.mclr ||
                    mac_ch !== e.mch || bypass !== e.byp || out_valid !== e.ov || overrun !== e.ovr ||
                    busy !== 1'b1 || (e.chk_c && coef_addr !== e.coef) || (e.chk_h && hist_addr !== e.hist)) begin
                    n_fail++;
                    $display("FAIL event: got cyc=%0d we=%b mac=%b clr=%b ch=%b byp=%b ov=%b ovr=%b busy=%b coef=%0d hist=%0d; expected cyc=%0d we=%b mac=%b clr=%b ch=%b byp=%b ov=%b ovr=%b busy=1 coef=%0d hist=%0d",
                             cyc, hist_we, mac_en, mac_clr, mac_ch, bypass, out_valid, overrun, busy, coef_addr, hist_addr,
                             e.cyc, e.hwe, e.men, e.mclr, e.mch, e.byp, e.ov, e.ovr, e.coef, e.hist);
                end
            end
        end
    end

    task automatic pulse_tick(input bit f);
        tick_in = 1; filter_en = f;
        step(1);
        tick_in = 0; filter_en = 0;
    endtask

    task automatic run_full(input int base, input int ovr);
        int t;
        t = cyc;
        exp_run(t, 1, base, ovr, 1000);
        pulse_tick(1);
        if (ovr > 0) begin
            step(t + ovr - cyc);
            tick_in = 1;
            step(1);
            tick_in = 0;
        end
        step(t + 3 + 2 * TAPS + LAT - cyc);
        chk("idle_hold", {busy, coef_addr, hist_addr}, {1'b0, 7'(2 * TAPS - 1), 6'((base + 1) % TAPS)});
    endtask

    initial begin
        int t;
        rst = 1; tick_in = 0; filter_en = 0; clr_in = 0;
        #3;
        chk("reset_outs", {coef_addr, hist_addr, hist_we, mac_en, mac_clr, mac_ch, bypass, out_valid, busy, overrun}, '0);
        step(2); rst = 0; step(1);

        // Reset in the middle of the left pass.
        t = cyc;
        exp_run(t, 1, 0, -1, 19);
        pulse_tick(1);
        step(t + 20 - cyc);
        rst = 1; #1;
        chk("async_rst", {coef_addr, hist_addr, hist_we, mac_en, mac_clr, mac_ch, bypass, out_valid, busy, overrun}, '0);
        step(1); rst = 0; step(1);

        run_full(0, -1);   // restart from slot 0
        run_full(1, 40);   // second sample, overrun mid-run

        for (int b = 2; b <= TAPS; b++) begin   // bypass ticks, last one wraps to slot 0
            t = cyc;
            exp_run(t, 0, b % TAPS, -1, 1000);
            pulse_tick(0);
            step(2);
        end

        // Clear beats a simultaneous tick while idle.
        tick_in = 1; clr_in = 1; filter_en = 1;
        step(1);
        tick_in = 0; clr_in = 0; filter_en = 0;
        chk("clr_tick_idle", {busy, overrun}, 2'b00);

        // Clear aborts a running filter pass; tick in the same cycle is dropped silently.
        t = cyc;
        exp_run(t, 1, 0, -1, 30);
        pulse_tick(1);
        step(t + 30 - cyc);
        clr_in = 1; tick_in = 1;
        step(1);
        clr_in = 0; tick_in = 0;
        chk("clr_abort", {busy, coef_addr, hist_addr, mac_en}, '0);
        step(90);
        chk("no_valid_after_clr", sb.size(), 0);

        t = cyc;
        exp_run(t, 0, 0, -1, 1000);
        pulse_tick(0);
        step(4);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
